clk_div_multi: RTL
==================

Name: clk_div_multi

Overview:
Parametrised, multi-channel successor to the fixed 1000/10/2 dividers. Each channel divides CLK by a runtime-programmable integer N ≥ 2, producing a ~50% duty output and a one-cycle wrap tick. Divisor changes take effect only at a period boundary, so outputs never glitch or produce runt periods. Sits between the board clock and the CPU step clock, display scan and debounce sample logic.

Parameters:
NUM_CH, 3, number of independent divider channels (1..8)
CNT_W, 16, counter and divisor width in bits
DEFAULT_DIV, 1000, divisor loaded into every channel at reset (2 ≤ DEFAULT_DIV < 2^CNT_W)

Ports:
CLK  in  1  system clock; all state is on its rising edge
RST_N  in  1  asynchronous active-low reset
en  in  NUM_CH  per-channel run enable
cfg_we  in  1  divisor write strobe, one-cycle
cfg_ch  in  3  target channel index for the write
cfg_div  in  CNT_W  new divisor value
clk_out  out  NUM_CH  registered divided clock per channel
tick  out  NUM_CH  one-CLK pulse per channel at end of each period
pend  out  NUM_CH  1 = channel holds an unapplied divisor

Behaviour:
- Interface: one clock, CLK; reset RST_N is asynchronous and active-low.
- Per-channel state: count, div_cur, div_pend, pend_valid.
- Reset values: count=0, div_cur=DEFAULT_DIV, div_pend=0, pend_valid=0, clk_out=0, tick=0, pend=0.
- Counting with en[i]=1:
  - count==div_cur-1: count←0, tick←1.
  - otherwise: count←count+1, tick←0.
- Output: clk_out[i]←(count ≥ div_cur>>1), evaluated on current registered values (fixed 1-cycle lag from count).
  - Even N: exactly N/2 cycles low, N/2 high.
  - Odd N: floor(N/2) low, ceil(N/2) high.
- Disabled (en[i]=0): count←0, clk_out←0, tick←0.
  - A pending divisor is applied immediately (div_cur←div_pend, pend_valid←0).
  - On re-enable, counting restarts from 0 with the low phase first.
- Config write, when cfg_we=1 and cfg_ch<NUM_CH:
  - div_pend[cfg_ch]←max(cfg_div,2); pend_valid←1.
  - A second write before application overwrites the first; last write wins.
  - cfg_ch ≥ NUM_CH: write ignored, no state changes.
- Application: at the wrap cycle (count==div_cur-1 with en=1), if pend_valid was set before this cycle, div_cur←div_pend and pend_valid←0.
  - The next period uses the new divisor from count 0.
- Simultaneous write and wrap, same channel:
  - Any older pending value is applied at this wrap.
  - The newly written value becomes pending for the next wrap.
- pend[i] mirrors pend_valid[i].
- Channels are fully independent; a write to one channel never disturbs another.
- Reset mid-period: all state returns to reset values asynchronously, including any pending divisor.
- Width rule: count compares against div_cur-1 in CNT_W bits. The 2 ≤ N clamp guarantees no underflow.

Decomposition:
- Shared package clk_div_pkg: DIV_MIN=2 and a clamp function max(x, DIV_MIN).
- One sub-module clk_div_chan: counter, divisor registers, pending logic, output register for a single channel, with an external write strobe.
- clk_div_multi generates NUM_CH instances and decodes cfg_ch into per-channel write strobes.

Test Plan:
- Reset with DEFAULT_DIV=1000, all en=1 -> each clk_out stays low 500 cycles then high 500 cycles; tick pulses every 1000 CLK; pend=0.
- Write ch1 div=10 mid-period (count=300) -> pend[1]=1. Current 1000-cycle period completes unchanged. Next periods are 5 low / 5 high; pend[1] clears at the wrap.
- Write ch0 div=7 then div=1 before wrap -> last write wins with clamp: ch0 period=2 (1 low, 1 high); ch2 unaffected.
- Write ch2 div=5 in the exact wrap cycle while no pending value exists -> the wrap keeps the old divisor; the next period (after one full old period) uses 5 (2 low / 3 high).
- Drop en[0] mid-period with div=10 pending -> clk_out[0]=0, tick[0]=0, pend[0]=0 next cycle. Re-enable -> period 10 starting low.
- Assert RST_N=0 asynchronously mid-high-phase with cfg_ch=5 writes -> outputs 0 immediately; div_cur back to 1000; the invalid-channel write has no effect.

Source files
------------

// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants and divisor clamp for the multi-channel clock divider
package clk_div_pkg;

    localparam int DIV_MIN  = 2;
    localparam int CH_IDX_W = 3;

    // Divisors below DIV_MIN would make div_cur-1 underflow or collapse the low phase.
    function automatic logic [31:0] div_clamp(input logic [31:0] x);
        return (x < 32'(DIV_MIN)) ? 32'(DIV_MIN) : x;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one divider channel: counter, active/pending divisor, registered clk_out and tick
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 1000
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             en,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_div,
    output logic             clk_out,
    output logic             tick,
    output logic             pend
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] DIV_ONE = CNT_W'(1);

    logic [CNT_W-1:0] count,    count_nx;
    logic [CNT_W-1:0] div_cur,  div_cur_nx;
    logic [CNT_W-1:0] div_pend, div_pend_nx;
    logic             pend_valid, pend_valid_nx;
    logic             clk_out_nx, tick_nx;
    logic             wrap, apply;

    assign wrap  = en && (count == (div_cur - DIV_ONE));
    // A held divisor lands at a period boundary, or at once while the channel is idle.
    assign apply = pend_valid && (wrap || !en);

    always_comb begin
        count_nx      = count;
        div_cur_nx    = div_cur;
        div_pend_nx   = div_pend;
        pend_valid_nx = pend_valid;

        if (!en || wrap) begin
            count_nx = '0;
        end else begin
            count_nx = count + DIV_ONE;
        end

        if (apply) begin
            div_cur_nx    = div_pend;
            pend_valid_nx = 1'b0;
        end

        // A write in the same cycle as an apply becomes the next pending value.
        if (wr_en) begin
            div_pend_nx   = CNT_W'(div_clamp(32'(wr_div)));
            pend_valid_nx = 1'b1;
        end
    end

    always_comb begin
        clk_out_nx = en && (count >= (div_cur >> 1));
        tick_nx    = wrap;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count      <= '0;
            div_cur    <= DIV_RST;
            div_pend   <= '0;
            pend_valid <= 1'b0;
            clk_out    <= 1'b0;
            tick       <= 1'b0;
        end else begin
            count      <= count_nx;
            div_cur    <= div_cur_nx;
            div_pend   <= div_pend_nx;
            pend_valid <= pend_valid_nx;
            clk_out    <= clk_out_nx;
            tick       <= tick_nx;
        end
    end

    assign pend = pend_valid;

endmodule

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - NUM_CH independent programmable clock dividers with a shared config write port
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 1000
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [NUM_CH-1:0]   en,
    input  logic                cfg_we,
    input  logic [CH_IDX_W-1:0] cfg_ch,
    input  logic [CNT_W-1:0]    cfg_div,
    output logic [NUM_CH-1:0]   clk_out,
    output logic [NUM_CH-1:0]   tick,
    output logic [NUM_CH-1:0]   pend
);

    logic              cfg_ok;
    logic [NUM_CH-1:0] ch_we;

    // Writes to channels that do not exist are dropped here.
    assign cfg_ok = cfg_we && (int'(cfg_ch) < NUM_CH);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ch_we[i] = cfg_ok && (cfg_ch == CH_IDX_W'(i));

        clk_div_chan #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .CLK     (CLK),
            .RST_N   (RST_N),
            .en      (en[i]),
            .wr_en   (ch_we[i]),
            .wr_div  (cfg_div),
            .clk_out (clk_out[i]),
            .tick    (tick[i]),
            .pend    (pend[i])
        );
    end

endmodule
